// File: rtl/rf_access_ctrl.sv
// Single-outstanding front-end that turns valid/ready commands into RF strobes and collects responses.
// Optional WAIT-state watchdog enabled by defining RF_TIMEOUT_EN.
module rf_access_ctrl #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_error,
    output logic [ADDR_W-1:0] rf_address,
    output logic              rf_read_en,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data,
    input  logic              rf_invalid_address,
    input  logic              rf_access_complete
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;

`ifdef RF_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef RF_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    wr_d        = cmd_write;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    cmd_ready_d = 1'b0;
                    rd_en_d     = !cmd_write;
                    wr_en_d     = cmd_write;
                    state_d     = S_STROBE;
                end
            end
            S_STROBE: begin
                state_d = S_WAIT;
`ifdef RF_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (rf_access_complete) begin
                    rdata_d = (wr_q || rf_invalid_address) ? '0 : rf_read_data;
                    err_d   = {1'b0, rf_invalid_address};
                    state_d = S_RESP;
                end
`ifdef RF_TIMEOUT_EN
                else begin
                    // Abort once the RF has been silent for TIMEOUT full WAIT cycles.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TO_VAL) begin
                        rdata_d = '0;
                        err_d   = 2'b10;
                        state_d = S_RESP;
                    end
                end
`endif
            end
            S_RESP: begin
                // rsp_valid lags RESP entry by one cycle so captured data is settled when offered.
                rsp_valid_d = 1'b1;
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 2'b00;
`ifdef RF_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef RF_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_error     = err_q;
    assign rf_address    = addr_q;
    assign rf_read_en    = rd_en_q;
    assign rf_write_en   = wr_en_q;
    assign rf_write_data = wdata_q;

endmodule
